frame_buffer_dbl: RTL and testbench
===================================

FRAME_BUFFER_DBL -- requirements
Module: frame_buffer_dbl

Interface
REQ-001 Parameters SHALL be as follows, one per line:
- PIXEL_W, 4, bits per pixel.
- DEPTH, 76800, pixels per bank.
- ADDR_W, 17, pixel address width; DEPTH <= 2**ADDR_W.
REQ-002 Ports SHALL be as follows, one per line:
- gpu_clk  in  1  sole clock, rising edge.
- gpu_rst  in  1  reset, asynchronous, active-high.
- gpu_pixel_data  in  PIXEL_W  write pixel value.
- gpu_pixel_addr  in  ADDR_W  write address, back bank.
- gpu_we  in  1  write enable.
- gpu_clear_req  in  1  single-cycle request to fill back bank.
- gpu_clear_color  in  PIXEL_W  fill value, sampled each clear cycle.
- gpu_swap_req  in  1  single-cycle request to swap banks at next frame end.
- gpu_busy  out  1  high while a clear is in progress.
- gpu_swap_pending  out  1  high while a swap awaits frame end.
- vga_pixel_addr  in  ADDR_W  read address, front bank.
- vga_frame_end  in  1  single-cycle pulse from display timing, last pixel of frame.
- vga_pixel_data  out  PIXEL_W  registered read data.
- front_sel  out  1  bank currently displayed (0 or 1).

Function
REQ-003 Storage SHALL be two banks of DEPTH x PIXEL_W; front = front_sel, back = ~front_sel.
REQ-004 Read SHALL be synchronous, 1-cycle latency: vga_pixel_data <= front[vga_pixel_addr] using front_sel as of the sampling edge; addr >= DEPTH returns 0.
REQ-005 FSM SHALL have states IDLE, CLEAR, SWAP_PEND; reset state IDLE.
REQ-006 In IDLE, gpu_we=1 with addr < DEPTH SHALL write gpu_pixel_data to back[addr]; addr >= DEPTH SHALL be ignored.
REQ-007 gpu_we in CLEAR or SWAP_PEND SHALL be ignored (no tearing of pending frame).
REQ-008 IDLE + gpu_clear_req SHALL enter CLEAR with counter=0; each CLEAR cycle writes gpu_clear_color to back[counter], counter+1; after the write at DEPTH-1, return to IDLE; clear takes exactly DEPTH cycles.
REQ-009 gpu_busy SHALL equal (state==CLEAR), registered.
REQ-010 IDLE + gpu_swap_req SHALL enter SWAP_PEND; gpu_swap_pending = (state==SWAP_PEND).
REQ-011 SWAP_PEND + vga_frame_end SHALL toggle front_sel on that edge and enter IDLE.
REQ-012 vga_frame_end in IDLE or CLEAR SHALL have no effect; swap_req and vga_frame_end in same IDLE cycle SHALL enter SWAP_PEND only (swap at the following frame end).
REQ-013 clear_req and swap_req in same IDLE cycle: clear wins, swap_req dropped.
REQ-014 gpu_we and clear_req in same IDLE cycle: write performed, CLEAR begins next cycle and overwrites it.
REQ-015 clear_req/swap_req outside IDLE SHALL be ignored (not queued).
REQ-016 Read and GPU write never target the same bank; read during swap edge returns old-front data.

Reset
REQ-017 On gpu_rst: state=IDLE, front_sel=0, counter=0, vga_pixel_data=0, gpu_busy=0, gpu_swap_pending=0; effective immediately, asynchronously.
REQ-018 Bank contents SHALL NOT be reset; reset mid-CLEAR aborts, partially cleared contents retained.

Verification (PIXEL_W=4, DEPTH=16, ADDR_W=5)
REQ-019 Write back[3]=0xA, swap_req, frame_end pulse -> front_sel 0->1 on that edge; read addr 3 returns 0xA one cycle later.
REQ-020 clear_req with color 0x5 -> gpu_busy high exactly 16 cycles; gpu_we during CLEAR ignored; after swap all 16 reads = 0x5, addr 20 reads 0.
REQ-021 swap_req and frame_end in same cycle -> gpu_swap_pending=1, front_sel unchanged; next frame_end swaps.
REQ-022 clear_req+swap_req together -> CLEAR only, gpu_swap_pending stays 0; gpu_we+clear_req together -> written value overwritten by clear color.
REQ-023 gpu_rst asserted mid-CLEAR (counter=7) and while SWAP_PEND -> outputs zero immediately, front_sel=0, back[0..6]=clear color retained.
REQ-024 Read addr 2 on the swap edge -> returns old front value; next read returns new front value.

Source files
------------

// File: rtl/frame_buffer_dbl.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_dbl
// Description : Double-buffered pixel store; GPU draws/clears the back bank,
//               display reads the front bank, swap deferred to frame end.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_dbl #(
  parameter int PIXEL_W = 4,
  parameter int DEPTH   = 76800,
  parameter int ADDR_W  = 17
) (
  input  logic               gpu_clk,
  input  logic               gpu_rst,
  input  logic [PIXEL_W-1:0] gpu_pixel_data,
  input  logic [ADDR_W-1:0]  gpu_pixel_addr,
  input  logic               gpu_we,
  input  logic               gpu_clear_req,
  input  logic [PIXEL_W-1:0] gpu_clear_color,
  input  logic               gpu_swap_req,
  output logic               gpu_busy,
  output logic               gpu_swap_pending,
  input  logic [ADDR_W-1:0]  vga_pixel_addr,
  input  logic               vga_frame_end,
  output logic [PIXEL_W-1:0] vga_pixel_data,
  output logic               front_sel
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_CLEAR     = 2'd1;
  localparam logic [1:0] S_SWAP_PEND = 2'd2;

  localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(DEPTH - 1);

  logic [PIXEL_W-1:0] bank0 [DEPTH];
  logic [PIXEL_W-1:0] bank1 [DEPTH];

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               front_sel_q, front_sel_d;
  logic [PIXEL_W-1:0] rd_data_q, rd_data_d;
  logic               busy_q, busy_d;
  logic               pend_q, pend_d;

  logic               w_wr_en;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [PIXEL_W-1:0] w_wr_data;
  logic [IDX_W-1:0]   w_rd_idx;
  logic               w_rd_in_range;
  logic               w_wr_in_range;

  assign w_rd_idx      = vga_pixel_addr[IDX_W-1:0];
  assign w_rd_in_range = ({1'b0, vga_pixel_addr} < C_DEPTH);
  assign w_wr_in_range = ({1'b0, gpu_pixel_addr} < C_DEPTH);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    front_sel_d = front_sel_q;
    w_wr_en     = 1'b0;
    w_wr_idx    = gpu_pixel_addr[IDX_W-1:0];
    w_wr_data   = gpu_pixel_data;

    case (state_q)
      S_IDLE: begin
        // A same-cycle write still lands; the clear starting next cycle overwrites it.
        w_wr_en = gpu_we && w_wr_in_range;
        if (gpu_clear_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (gpu_swap_req) begin
          state_d = S_SWAP_PEND;
        end
      end
      S_CLEAR: begin
        w_wr_en   = 1'b1;
        w_wr_idx  = cnt_q[IDX_W-1:0];
        w_wr_data = gpu_clear_color;
        if (cnt_q == C_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SWAP_PEND: begin
        if (vga_frame_end) begin
          front_sel_d = ~front_sel_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CLEAR);
    pend_d = (state_d == S_SWAP_PEND);

    // Read uses the pre-swap front bank, so the swap edge still returns old data.
    rd_data_d = '0;
    if (w_rd_in_range) begin
      rd_data_d = front_sel_q ? bank1[w_rd_idx] : bank0[w_rd_idx];
    end
  end

  always_ff @(posedge gpu_clk or posedge gpu_rst) begin
    if (gpu_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      front_sel_q <= 1'b0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      front_sel_q <= front_sel_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
    end
  end

  // Bank contents survive reset; writes always go to the back bank.
  always_ff @(posedge gpu_clk) begin
    if (w_wr_en && !gpu_rst) begin
      if (front_sel_q) begin
        bank0[w_wr_idx] <= w_wr_data;
      end else begin
        bank1[w_wr_idx] <= w_wr_data;
      end
    end
  end

  assign gpu_busy         = busy_q;
  assign gpu_swap_pending = pend_q;
  assign vga_pixel_data   = rd_data_q;
  assign front_sel        = front_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_dbl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buffer_dbl
// Description : Directed self-checking bench for frame_buffer_dbl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buffer_dbl;

  localparam int PIXEL_W = 4;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 5;

  logic               gpu_clk = 1'b0;
  logic               gpu_rst;
  logic [PIXEL_W-1:0] gpu_pixel_data;
  logic [ADDR_W-1:0]  gpu_pixel_addr;
  logic               gpu_we;
  logic               gpu_clear_req;
  logic [PIXEL_W-1:0] gpu_clear_color;
  logic               gpu_swap_req;
  logic               gpu_busy;
  logic               gpu_swap_pending;
  logic [ADDR_W-1:0]  vga_pixel_addr;
  logic               vga_frame_end;
  logic [PIXEL_W-1:0] vga_pixel_data;
  logic               front_sel;

  frame_buffer_dbl #(.PIXEL_W(PIXEL_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .gpu_clk          (gpu_clk),
    .gpu_rst          (gpu_rst),
    .gpu_pixel_data   (gpu_pixel_data),
    .gpu_pixel_addr   (gpu_pixel_addr),
    .gpu_we           (gpu_we),
    .gpu_clear_req    (gpu_clear_req),
    .gpu_clear_color  (gpu_clear_color),
    .gpu_swap_req     (gpu_swap_req),
    .gpu_busy         (gpu_busy),
    .gpu_swap_pending (gpu_swap_pending),
    .vga_pixel_addr   (vga_pixel_addr),
    .vga_frame_end    (vga_frame_end),
    .vga_pixel_data   (vga_pixel_data),
    .front_sel        (front_sel)
  );

  always #5 gpu_clk = ~gpu_clk;

  int checks = 0;
  int errors = 0;

  logic [PIXEL_W-1:0] m_bank [2][DEPTH];
  logic               m_front;
  logic [PIXEL_W-1:0] exp_q [$];

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge gpu_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PIXEL_W-1:0] model_rd(input int a);
    return (a < DEPTH) ? m_bank[m_front][a] : '0;
  endfunction

  task automatic rd(input int a);
    vga_pixel_addr = ADDR_W'(a);
    exp_q.push_back(model_rd(a));
    step();
    chk($sformatf("rd[%0d]", a), 32'(vga_pixel_data), 32'(exp_q.pop_front()));
  endtask

  task automatic wr(input int a, input logic [PIXEL_W-1:0] d);
    gpu_we = 1'b1; gpu_pixel_addr = ADDR_W'(a); gpu_pixel_data = d;
    step();
    gpu_we = 1'b0;
    if (a < DEPTH) m_bank[~m_front][a] = d;
  endtask

  // Clear with optional same-cycle write/swap; stray we and swap_req injected mid-clear.
  task automatic do_clear(input logic [PIXEL_W-1:0] color, input bit with_we, input bit with_swap);
    int n;
    gpu_clear_req = 1'b1; gpu_clear_color = color;
    gpu_swap_req = with_swap;
    if (with_we) begin
      gpu_we = 1'b1; gpu_pixel_addr = 5'd1; gpu_pixel_data = 4'h9;
    end
    step();
    gpu_clear_req = 1'b0; gpu_swap_req = 1'b0; gpu_we = 1'b0;
    chk("clear_busy_start", 32'(gpu_busy), 32'd1);
    chk("clear_pend_start", 32'(gpu_swap_pending), 32'd0);
    n = 0;
    while (gpu_busy === 1'b1 && n < 40) begin
      n++;
      gpu_swap_req = (n == 3);
      gpu_we = 1'b1; gpu_pixel_addr = 5'd4; gpu_pixel_data = 4'hF;
      step();
    end
    gpu_swap_req = 1'b0; gpu_we = 1'b0;
    chk("clear_busy_cycles", 32'(n), 32'd16);
    chk("clear_pend_end", 32'(gpu_swap_pending), 32'd0);
    for (int i = 0; i < DEPTH; i++) m_bank[~m_front][i] = color;
  endtask

  task automatic do_swap();
    gpu_swap_req = 1'b1;
    step();
    gpu_swap_req = 1'b0;
    chk("swap_pend", 32'(gpu_swap_pending), 32'd1);
    chk("swap_front_hold", 32'(front_sel), 32'(m_front));
    vga_frame_end = 1'b1;
    step();
    vga_frame_end = 1'b0;
    m_front = ~m_front;
    chk("swap_front", 32'(front_sel), 32'(m_front));
    chk("swap_pend_clr", 32'(gpu_swap_pending), 32'd0);
  endtask

  initial begin
    gpu_rst = 1'b1; gpu_pixel_data = '0; gpu_pixel_addr = '0; gpu_we = 1'b0;
    gpu_clear_req = 1'b0; gpu_clear_color = '0; gpu_swap_req = 1'b0;
    vga_pixel_addr = '0; vga_frame_end = 1'b0;
    m_front = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) m_bank[b][i] = 'x;

    step(); step();
    chk("rst_busy", 32'(gpu_busy), 32'd0);
    chk("rst_pend", 32'(gpu_swap_pending), 32'd0);
    chk("rst_front", 32'(front_sel), 32'd0);
    chk("rst_pix", 32'(vga_pixel_data), 32'd0);
    gpu_rst = 1'b0;
    step();

    // Fill bank1 with 5, display it, read all plus an out-of-range address.
    do_clear(4'h5, 1'b0, 1'b0);
    do_swap();
    for (int i = 0; i < DEPTH; i++) rd(i);
    rd(20);

    // Fill bank0 with 3, draw a pixel, then read addr 2 across the swap edge.
    do_clear(4'h3, 1'b0, 1'b0);
    wr(3, 4'hA);
    wr(20, 4'hF);
    gpu_swap_req = 1'b1;
    step();
    gpu_swap_req = 1'b0;
    chk("edge_pend", 32'(gpu_swap_pending), 32'd1);
    vga_pixel_addr = 5'd2;
    exp_q.push_back(model_rd(2));
    vga_frame_end = 1'b1;
    step();
    vga_frame_end = 1'b0;
    m_front = ~m_front;
    chk("edge_rd_old", 32'(vga_pixel_data), 32'(exp_q.pop_front()));
    chk("edge_front", 32'(front_sel), 32'd0);
    rd(2);
    rd(3);

    // Front 0 -> 1 with freshly drawn back[3].
    wr(3, 4'hA);
    do_swap();
    rd(3);

    // Frame end with no pending swap is ignored.
    vga_frame_end = 1'b1;
    step();
    vga_frame_end = 1'b0;
    chk("idle_fe_front", 32'(front_sel), 32'd1);

    // Swap request coincident with frame end waits for the next one.
    gpu_swap_req = 1'b1; vga_frame_end = 1'b1;
    step();
    gpu_swap_req = 1'b0; vga_frame_end = 1'b0;
    chk("coinc_pend", 32'(gpu_swap_pending), 32'd1);
    chk("coinc_front", 32'(front_sel), 32'd1);
    step();
    chk("coinc_pend_hold", 32'(gpu_swap_pending), 32'd1);
    vga_frame_end = 1'b1;
    step();
    vga_frame_end = 1'b0;
    m_front = 1'b0;
    chk("coinc_front_swap", 32'(front_sel), 32'd0);
    rd(3);

    // Clear wins over swap; same-cycle write is overwritten by the clear.
    do_clear(4'hC, 1'b1, 1'b1);
    do_swap();
    rd(1);
    rd(3);

    // Asynchronous reset seven cycles into a clear of bank0.
    vga_pixel_addr = 5'd1;
    gpu_clear_req = 1'b1; gpu_clear_color = 4'h7;
    step();
    gpu_clear_req = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("pre_rst_pix", 32'(vga_pixel_data), 32'hC);
    chk("pre_rst_busy", 32'(gpu_busy), 32'd1);
    #2 gpu_rst = 1'b1;
    #1;
    chk("arst_busy", 32'(gpu_busy), 32'd0);
    chk("arst_pix", 32'(vga_pixel_data), 32'd0);
    chk("arst_front", 32'(front_sel), 32'd0);
    chk("arst_pend", 32'(gpu_swap_pending), 32'd0);
    step();
    gpu_rst = 1'b0;
    m_front = 1'b0;
    for (int i = 0; i < 7; i++) m_bank[0][i] = 4'h7;
    for (int i = 0; i < 9; i++) rd(i);

    // Asynchronous reset while a swap is pending.
    do_swap();
    gpu_swap_req = 1'b1;
    step();
    gpu_swap_req = 1'b0;
    chk("pend_before_rst", 32'(gpu_swap_pending), 32'd1);
    #2 gpu_rst = 1'b1;
    #1;
    chk("arst_pend2", 32'(gpu_swap_pending), 32'd0);
    chk("arst_front2", 32'(front_sel), 32'd0);
    step();
    gpu_rst = 1'b0;
    m_front = 1'b0;
    step();
    rd(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
